lbist_pattern_scheduler: RTL and testbench

Sequences the LBIST phase of the STRAIT systolic array. It runs the stuck-at (SA) pattern set and then the transition-delay (TD) pattern set. For each pattern it fetches stimulus and expected answers from eNVM, drives weight load and activation/partial-sum injection into the array, and checks every column's partial-sum output. It sits between the hybrid BIST top, the eNVM and the array input mux, and reports per-column fail maps that the recovery logic consumes.

---
 rtl/strait_pkg.sv | 26 ++
 rtl/lbist_column_comparator.sv | 21 ++
 rtl/lbist_pattern_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_lbist_pattern_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strait_pkg.sv
// Shared types and constants for the STRAIT LBIST pattern scheduler.
package strait_pkg;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoadW,
        StApply,
        StCapture,
        StWait,
        StDone
    } lbist_state_e;

    // test_type encoding, also used directly as the eNVM table select
    localparam logic TEST_SA = 1'b0;
    localparam logic TEST_TD = 1'b1;

    // Default array geometry and the partial-sum slice width it implies
    localparam int unsigned DEF_SYSTOLIC_SIZE     = 8;
    localparam int unsigned DEF_WEIGHT_WIDTH      = 8;
    localparam int unsigned DEF_ACTIVATION_WIDTH  = 8;
    localparam int unsigned DEF_PSUM_WIDTH        =
        DEF_WEIGHT_WIDTH + DEF_ACTIVATION_WIDTH + $clog2(DEF_SYSTOLIC_SIZE);

endpackage

// File: rtl/lbist_column_comparator.sv
// Combinational per-column compare of the array output against one expected value.
module lbist_column_comparator
    import strait_pkg::*;
#(
    parameter int unsigned SYSTOLIC_SIZE     = DEF_SYSTOLIC_SIZE,
    parameter int unsigned PARTIAL_SUM_WIDTH = DEF_PSUM_WIDTH
) (
    input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] result_flat,
    input  logic [PARTIAL_SUM_WIDTH-1:0]               expected,
    output logic [SYSTOLIC_SIZE-1:0]                   mismatch
);

    // Every column receives the same broadcast stimulus, so all share one expected value
    always_comb begin
        mismatch = '0;
        for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
            mismatch[c] = result_flat[c*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH] != expected;
        end
    end

endmodule

// File: rtl/lbist_pattern_scheduler.sv
// LBIST sequencer: runs the SA pattern set then the TD pattern set from eNVM,
// drives the array and accumulates sticky per-column fail maps.
module lbist_pattern_scheduler
    import strait_pkg::*;
#(
    parameter int unsigned SYSTOLIC_SIZE         = DEF_SYSTOLIC_SIZE,
    parameter int unsigned WEIGHT_WIDTH          = DEF_WEIGHT_WIDTH,
    parameter int unsigned ACTIVATION_WIDTH      = DEF_ACTIVATION_WIDTH,
    parameter int unsigned PARTIAL_SUM_WIDTH     = DEF_PSUM_WIDTH,
    parameter int unsigned SA_TEST_PATTERN_DEPTH = 12,
    parameter int unsigned TD_TEST_PATTERN_DEPTH = 18,
    parameter int unsigned PATTERN_ADDR_WIDTH    = 5,
    parameter int unsigned TIMEOUT_CYCLES        = 64
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    output logic                                       envm_rd_en,
    output logic                                       envm_sel,
    output logic [PATTERN_ADDR_WIDTH-1:0]              envm_rd_addr,
    input  logic                                       envm_rd_valid,
    input  logic [WEIGHT_WIDTH-1:0]                    pat_w1,
    input  logic [WEIGHT_WIDTH-1:0]                    pat_w2,
    input  logic [ACTIVATION_WIDTH-1:0]                pat_a1,
    input  logic [ACTIVATION_WIDTH-1:0]                pat_a2,
    input  logic [PARTIAL_SUM_WIDTH-1:0]               pat_p1,
    input  logic [PARTIAL_SUM_WIDTH-1:0]               pat_p2,
    input  logic [PARTIAL_SUM_WIDTH-1:0]               pat_ans1,
    input  logic [PARTIAL_SUM_WIDTH-1:0]               pat_ans2,
    output logic                                       weight_valid,
    output logic [WEIGHT_WIDTH-1:0]                    weight_out,
    output logic                                       act_valid,
    output logic [ACTIVATION_WIDTH-1:0]                act_out,
    output logic [PARTIAL_SUM_WIDTH-1:0]               psum_out,
    input  logic                                       result_valid,
    input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] result_flat,
    output logic                                       busy,
    output logic                                       done,
    output logic [SYSTOLIC_SIZE-1:0]                   sa_fail_map,
    output logic [SYSTOLIC_SIZE-1:0]                   td_fail_map,
    output logic                                       td_error_flag
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PATTERN_ADDR_WIDTH-1:0] SA_LAST =
        PATTERN_ADDR_WIDTH'(SA_TEST_PATTERN_DEPTH - 1);
    localparam logic [PATTERN_ADDR_WIDTH-1:0] TD_LAST =
        PATTERN_ADDR_WIDTH'(TD_TEST_PATTERN_DEPTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    lbist_state_e state_q, state_d;

    logic                          test_type_q;
    logic [PATTERN_ADDR_WIDTH-1:0] index_q;
    logic                          fetch_issued_q;
    logic                          res_k_q;
    logic [TMO_W-1:0]              tmo_cnt_q;
    logic [WEIGHT_WIDTH-1:0]       w1_q, w2_q;
    logic [ACTIVATION_WIDTH-1:0]   a1_q, a2_q;
    logic [PARTIAL_SUM_WIDTH-1:0]  p1_q, p2_q, ans1_q, ans2_q;
    logic [SYSTOLIC_SIZE-1:0]      sa_fail_map_q, td_fail_map_q;

    logic                          accept, final_res, timeout, advance, last_pattern;
    logic [PARTIAL_SUM_WIDTH-1:0]  expected;
    logic [SYSTOLIC_SIZE-1:0]      mismatch;

    lbist_column_comparator #(
        .SYSTOLIC_SIZE     (SYSTOLIC_SIZE),
        .PARTIAL_SUM_WIDTH (PARTIAL_SUM_WIDTH)
    ) u_cmp (
        .result_flat (result_flat),
        .expected    (expected),
        .mismatch    (mismatch)
    );

    // Result acceptance, timeout and pattern-advance decode
    always_comb begin
        accept       = result_valid && (state_q == StCapture || state_q == StWait);
        // SA expects one result; TD is complete on its second
        final_res    = accept && (test_type_q == TEST_SA || res_k_q);
        // A result arriving on the timeout cycle takes priority over the forced fail
        timeout      = (state_q == StWait) && !accept && (tmo_cnt_q == TMO_LAST);
        advance      = (state_q == StWait) && (final_res || timeout);
        last_pattern = index_q == ((test_type_q == TEST_TD) ? TD_LAST : SA_LAST);
        expected     = res_k_q ? ans2_q : ans1_q;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StFetch;
            StFetch:   if (envm_rd_valid) state_d = StLoadW;
            StLoadW:   state_d = StApply;
            StApply:   state_d = (test_type_q == TEST_TD) ? StCapture : StWait;
            StCapture: state_d = StWait;
            StWait: begin
                if (advance) begin
                    state_d = (last_pattern && test_type_q == TEST_TD) ? StDone : StFetch;
                end
            end
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Array and eNVM drive; data buses stay 0 whenever their strobe is low
    always_comb begin
        envm_rd_en   = 1'b0;
        envm_sel     = 1'b0;
        envm_rd_addr = '0;
        weight_valid = 1'b0;
        weight_out   = '0;
        act_valid    = 1'b0;
        act_out      = '0;
        psum_out     = '0;
        case (state_q)
            StFetch: begin
                if (!fetch_issued_q) begin
                    envm_rd_en   = 1'b1;
                    envm_sel     = test_type_q;
                    envm_rd_addr = index_q;
                end
            end
            StLoadW: begin
                weight_valid = 1'b1;
                weight_out   = w1_q;
            end
            StApply: begin
                act_valid = 1'b1;
                act_out   = a1_q;
                psum_out  = p1_q;
            end
            StCapture: begin
                weight_valid = 1'b1;
                weight_out   = w2_q;
                act_valid    = 1'b1;
                act_out      = a2_q;
                psum_out     = p2_q;
            end
            default: ;
        endcase
    end

    // Counters, pattern latches and sticky fail maps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            test_type_q    <= TEST_SA;
            index_q        <= '0;
            fetch_issued_q <= 1'b0;
            res_k_q        <= 1'b0;
            tmo_cnt_q      <= '0;
            w1_q           <= '0;
            w2_q           <= '0;
            a1_q           <= '0;
            a2_q           <= '0;
            p1_q           <= '0;
            p2_q           <= '0;
            ans1_q         <= '0;
            ans2_q         <= '0;
            sa_fail_map_q  <= '0;
            td_fail_map_q  <= '0;
        end else begin
            // Read strobe is single-cycle even if the eNVM answers late
            fetch_issued_q <= (state_q == StFetch) && !envm_rd_valid;

            if (state_q == StFetch && envm_rd_valid) begin
                w1_q   <= pat_w1;
                w2_q   <= pat_w2;
                a1_q   <= pat_a1;
                a2_q   <= pat_a2;
                p1_q   <= pat_p1;
                p2_q   <= pat_p2;
                ans1_q <= pat_ans1;
                ans2_q <= pat_ans2;
            end

            // Saturates so a TD launch landing on the last WAIT cycle defers the timeout
            if (state_q != StWait) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q != TMO_LAST) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end

            if (state_q == StFetch) begin
                res_k_q <= 1'b0;
            end else if (accept) begin
                res_k_q <= 1'b1;
            end

            if (accept) begin
                if (test_type_q == TEST_TD) td_fail_map_q <= td_fail_map_q | mismatch;
                else                        sa_fail_map_q <= sa_fail_map_q | mismatch;
            end else if (timeout) begin
                if (test_type_q == TEST_TD) td_fail_map_q <= '1;
                else                        sa_fail_map_q <= '1;
            end

            if (state_q == StIdle && start) begin
                sa_fail_map_q <= '0;
                td_fail_map_q <= '0;
                test_type_q   <= TEST_SA;
                index_q       <= '0;
            end else if (advance) begin
                if (!last_pattern) begin
                    index_q <= index_q + PATTERN_ADDR_WIDTH'(1);
                end else if (test_type_q == TEST_SA) begin
                    test_type_q <= TEST_TD;
                    index_q     <= '0;
                end
            end
        end
    end

    assign busy          = state_q != StIdle;
    assign done          = state_q == StDone;
    assign sa_fail_map   = sa_fail_map_q;
    assign td_fail_map   = td_fail_map_q;
    assign td_error_flag = |td_fail_map_q;

endmodule

// File: tb/tb_lbist_pattern_scheduler.sv
// Scoreboard bench for lbist_pattern_scheduler with eNVM and systolic-array models.
module tb_lbist_pattern_scheduler;

    localparam int N   = 8;
    localparam int PSW = 19;

    logic           clk, rst, start;
    logic           envm_rd_en, envm_sel, envm_rd_valid;
    logic [4:0]     envm_rd_addr;
    logic [7:0]     pat_w1, pat_w2, pat_a1, pat_a2;
    logic [PSW-1:0] pat_p1, pat_p2, pat_ans1, pat_ans2;
    logic           weight_valid, act_valid, result_valid;
    logic [7:0]     weight_out, act_out;
    logic [PSW-1:0] psum_out;
    logic [N*PSW-1:0] result_flat;
    logic           busy, done, td_error_flag;
    logic [N-1:0]   sa_fail_map, td_fail_map;

    lbist_pattern_scheduler dut (
        .clk (clk), .rst (rst), .start (start),
        .envm_rd_en (envm_rd_en), .envm_sel (envm_sel), .envm_rd_addr (envm_rd_addr),
        .envm_rd_valid (envm_rd_valid),
        .pat_w1 (pat_w1), .pat_w2 (pat_w2), .pat_a1 (pat_a1), .pat_a2 (pat_a2),
        .pat_p1 (pat_p1), .pat_p2 (pat_p2), .pat_ans1 (pat_ans1), .pat_ans2 (pat_ans2),
        .weight_valid (weight_valid), .weight_out (weight_out),
        .act_valid (act_valid), .act_out (act_out), .psum_out (psum_out),
        .result_valid (result_valid), .result_flat (result_flat),
        .busy (busy), .done (done),
        .sa_fail_map (sa_fail_map), .td_fail_map (td_fail_map),
        .td_error_flag (td_error_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model configuration
    int   lat = 3;
    logic fault_en = 1'b0, f_sel = 1'b0, sup_en = 1'b0, sup_sel = 1'b0;
    int   f_addr = 0, f_k = 0, f_col = 0, sup_addr = 0;

    typedef struct { int due; logic [N*PSW-1:0] data; } pend_t;
    typedef struct { logic wv; logic av; logic [7:0] w; logic [7:0] a; logic [PSW-1:0] p; } drv_t;
    typedef struct { int start_cyc; int lat; logic [7:0] sa; logic [7:0] td; } run_t;
    typedef struct { logic sel; logic [4:0] addr; } rd_t;

    pend_t pipe[$];
    drv_t  drv_q[$];
    run_t  run_q[$];
    rd_t   rd_q[$];

    // Hand-chosen pattern table contents
    function automatic logic [7:0] f_w(input logic sel, input int a, input int k);
        int v;
        v = (k == 0 ? 17 : 90) + a * 7 + (sel ? 64 : 0);
        return v[7:0];
    endfunction
    function automatic logic [7:0] f_a(input logic sel, input int a, input int k);
        int v;
        v = (k == 0 ? 3 : 200) + a * 11 + (sel ? 5 : 0);
        return v[7:0];
    endfunction
    function automatic logic [PSW-1:0] f_p(input logic sel, input int a, input int k);
        int v;
        v = (k == 0 ? 1000 : 70000) + a * 123 + (sel ? 30000 : 0);
        return v[PSW-1:0];
    endfunction
    function automatic logic [PSW-1:0] f_ans(input logic sel, input int a, input int k);
        int v;
        logic [PSW-1:0] r;
        v = (sel ? 150000 : 4000) + a * 977;
        r = v[PSW-1:0];
        if (k != 0) r = r ^ 19'h15555;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // eNVM model, read latency 1
    logic       envm_pend = 1'b0;
    logic       pend_sel = 1'b0, cur_sel = 1'b0;
    int         pend_addr = 0, cur_addr = 0;
    always @(negedge clk) begin
        if (rst) begin
            envm_pend     = 1'b0;
            envm_rd_valid = 1'b0;
        end else begin
            envm_rd_valid = envm_pend;
            if (envm_pend) begin
                pat_w1   = f_w(pend_sel, pend_addr, 0);
                pat_w2   = f_w(pend_sel, pend_addr, 1);
                pat_a1   = f_a(pend_sel, pend_addr, 0);
                pat_a2   = f_a(pend_sel, pend_addr, 1);
                pat_p1   = f_p(pend_sel, pend_addr, 0);
                pat_p2   = f_p(pend_sel, pend_addr, 1);
                pat_ans1 = f_ans(pend_sel, pend_addr, 0);
                pat_ans2 = f_ans(pend_sel, pend_addr, 1);
            end else begin
                pat_w1 = 8'hEE; pat_w2 = 8'hEE; pat_a1 = 8'hEE; pat_a2 = 8'hEE;
                pat_p1 = '1; pat_p2 = '1; pat_ans1 = '1; pat_ans2 = '1;
            end
            envm_pend = envm_rd_en;
            if (envm_rd_en) begin
                pend_sel  = envm_sel;
                pend_addr = int'(envm_rd_addr);
                cur_sel   = pend_sel;
                cur_addr  = pend_addr;
                // Expected array drive sequence for this pattern
                drv_q.push_back('{1'b1, 1'b0, f_w(pend_sel, pend_addr, 0), 8'h00, 19'h0});
                drv_q.push_back('{1'b0, 1'b1, 8'h00, f_a(pend_sel, pend_addr, 0),
                                  f_p(pend_sel, pend_addr, 0)});
                if (pend_sel) begin
                    drv_q.push_back('{1'b1, 1'b1, f_w(pend_sel, pend_addr, 1),
                                      f_a(pend_sel, pend_addr, 1), f_p(pend_sel, pend_addr, 1)});
                end
            end
        end
    end

    // Systolic-array model: fixed latency lat, returns the table answer with optional fault
    always @(negedge clk) begin
        if (rst) begin
            pipe.delete();
            result_valid = 1'b0;
            result_flat  = '0;
        end else begin
            result_valid = 1'b0;
            result_flat  = '0;
            if (pipe.size() > 0 && pipe[0].due == cyc) begin
                result_valid = 1'b1;
                result_flat  = pipe[0].data;
                void'(pipe.pop_front());
            end
            if (act_valid && !(sup_en && cur_sel == sup_sel && cur_addr == sup_addr)) begin
                pend_t e;
                int k;
                k = weight_valid ? 1 : 0;
                e.due = cyc + lat;
                for (int c = 0; c < N; c++) begin
                    e.data[c*PSW +: PSW] = f_ans(cur_sel, cur_addr, k);
                end
                if (fault_en && cur_sel == f_sel && cur_addr == f_addr && k == f_k) begin
                    e.data[f_col*PSW] = ~e.data[f_col*PSW];
                end
                pipe.push_back(e);
            end
        end
    end

    // Monitor: eNVM reads, array drive, and end-of-run results against the scoreboards
    always @(negedge clk) begin
        if (!rst) begin
            if (envm_rd_en) begin
                if (rd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: got read sel=%0d addr=%0d want none",
                             envm_sel, envm_rd_addr);
                end else begin
                    rd_t r;
                    r = rd_q.pop_front();
                    chk("rd_sel", 64'(envm_sel), 64'(r.sel));
                    chk("rd_addr", 64'(envm_rd_addr), 64'(r.addr));
                end
            end
            if (weight_valid || act_valid) begin
                if (drv_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL drv_unexpected: got wv=%0d av=%0d want none",
                             weight_valid, act_valid);
                end else begin
                    drv_t d;
                    d = drv_q.pop_front();
                    chk("drv_wv", 64'(weight_valid), 64'(d.wv));
                    chk("drv_av", 64'(act_valid), 64'(d.av));
                    chk("drv_w", 64'(weight_out), 64'(d.w));
                    chk("drv_a", 64'(act_out), 64'(d.a));
                    chk("drv_p", 64'(psum_out), 64'(d.p));
                end
            end
            if (done) begin
                done_cnt++;
                if (run_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got done=1 want 0");
                end else begin
                    run_t r;
                    r = run_q.pop_front();
                    chk("done_latency", 64'(cyc - r.start_cyc), 64'(r.lat));
                    chk("done_sa_map", 64'(sa_fail_map), 64'(r.sa));
                    chk("done_td_map", 64'(td_fail_map), 64'(r.td));
                    chk("done_td_flag", 64'(td_error_flag), 64'(r.td != 8'h00));
                    chk("done_busy", 64'(busy), 64'(1));
                    chk("done_reads_left", 64'(rd_q.size()), 64'(0));
                end
            end
        end
    end

    task automatic start_run(input int exp_lat, input logic [7:0] sa, input logic [7:0] td);
        @(negedge clk);
        for (int i = 0; i < 12; i++) rd_q.push_back('{1'b0, 5'(i)});
        for (int i = 0; i < 18; i++) rd_q.push_back('{1'b1, 5'(i)});
        run_q.push_back('{cyc, exp_lat, sa, td});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            total++; bad++;
            $display("FAIL done_wait: got no done within %0d cycles want done", budget);
        end
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n;
        rst = 1'b1;
        start = 1'b0;
        result_valid = 1'b0;
        result_flat = '0;
        envm_rd_valid = 1'b0;
        pat_w1 = '0; pat_w2 = '0; pat_a1 = '0; pat_a2 = '0;
        pat_p1 = '0; pat_p2 = '0; pat_ans1 = '0; pat_ans2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_rd_en", 64'(envm_rd_en), 64'(0));
        chk("rst_maps", 64'({sa_fail_map, td_fail_map}), 64'(0));
        rst = 1'b0;

        // 1: fault-free, L=3, extra start while busy must be ignored
        lat = 3;
        start_run(229, 8'h00, 8'h00);
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);

        // 2: SA pattern 3, column 5 corrupted
        fault_en = 1'b1; f_sel = 1'b0; f_addr = 3; f_k = 0; f_col = 5;
        start_run(229, 8'h20, 8'h00);
        wait_done(400);

        // 3: TD pattern 7, only capture result, column 0 corrupted
        f_sel = 1'b1; f_addr = 7; f_k = 1; f_col = 0;
        start_run(229, 8'h00, 8'h01);
        wait_done(400);

        // 4: no result for SA pattern 0 -> 64-cycle timeout forces all-ones
        fault_en = 1'b0;
        sup_en = 1'b1; sup_sel = 1'b0; sup_addr = 0;
        start_run(229 - 7 + 68, 8'hFF, 8'h00);
        wait_done(500);
        sup_en = 1'b0;

        // 5: new start clears the maps left by the previous run
        start_run(229, 8'h00, 8'h00);
        chk("restart_sa_cleared", 64'(sa_fail_map), 64'(0));
        chk("restart_busy", 64'(busy), 64'(1));
        wait_done(400);

        // 6: L=1, TD launch result lands in CAPTURE
        lat = 1;
        start_run(12 * 5 + 18 * 6 + 1, 8'h00, 8'h00);
        wait_done(400);

        // 7: reset during TD pattern 10
        lat = 3;
        fault_en = 1'b1; f_sel = 1'b0; f_addr = 3; f_k = 0; f_col = 5;
        start_run(229, 8'h20, 8'h00);
        n = 0;
        while (!(envm_rd_en && envm_sel && envm_rd_addr == 5'd10) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("td10_reached", 64'(envm_rd_en && envm_sel && envm_rd_addr == 5'd10), 64'(1));
        chk("pre_rst_sa_map", 64'(sa_fail_map), 64'(8'h20));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        chk("arst_envm", 64'({envm_rd_en, envm_sel, envm_rd_addr}), 64'(0));
        chk("arst_drive", 64'({weight_valid, act_valid, weight_out, act_out}), 64'(0));
        chk("arst_psum", 64'(psum_out), 64'(0));
        chk("arst_maps", 64'({sa_fail_map, td_fail_map, td_error_flag}), 64'(0));
        run_q.delete();
        rd_q.delete();
        drv_q.delete();
        fault_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (300) @(negedge clk);
        chk("no_done_after_rst", 64'(done_cnt), 64'(d0));

        // 8: clean run after the mid-run reset
        start_run(229, 8'h00, 8'h00);
        wait_done(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
